// File: rtl/apb_cmd_master.sv
// apb_cmd_master: buffers read/write commands in a small FIFO and issues each as a two-phase APB transfer.
// Ports:
//   pclk, preset                  clock, asynchronous active-high reset
//   cmd_valid / cmd_ready         command handshake; cmd_write, cmd_addr, cmd_wdata carry the command
//   rsp_valid                     one-cycle response pulse carrying rsp_rdata and rsp_err
//   busy                          commands queued or a transfer in progress
//   psel, penable, paddr,
//   pwdata, pwrite                APB requester outputs
//   pready, pslverr, prdata       APB completer inputs
// Optional feature: define APB_CMD_MASTER_TIMEOUT_EN to abort an ACCESS phase after
// TIMEOUT_CYCLES cycles without pready (response then reports rsp_err=1, rsp_rdata=0).
`timescale 1ns/1ps
module apb_cmd_master #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        pclk,
    input  logic        preset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic [31:0] paddr,
    output logic [31:0] pwdata,
    output logic        pwrite,
    output logic        psel,
    output logic        penable,
    input  logic        pready,
    input  logic        pslverr,
    input  logic [31:0] prdata
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t        state_q, state_d;
    logic [64:0]   fifo_mem [FIFO_DEPTH];
    logic [64:0]   head;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
    logic [31:0]   paddr_q, paddr_d, pwdata_q, pwdata_d;
    logic          rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;
    logic          empty, push, pop, abort, done;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("apb_cmd_master: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 1");
    end

    assign empty     = count_q == '0;
    assign cmd_ready = count_q != CW'(FIFO_DEPTH);
    assign push      = cmd_valid && cmd_ready;
    assign head      = fifo_mem[rd_ptr_q];
    assign done      = state_q == ACCESS && (pready || abort);
    assign busy      = !empty || state_q != IDLE;

    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

`ifdef APB_CMD_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TW-1:0] tmo_q, tmo_d;
    // Abort on the edge where the count of stalled ACCESS cycles reaches TIMEOUT_CYCLES.
    assign abort = state_q == ACCESS && !pready && tmo_q == TW'(TIMEOUT_CYCLES - 1);
    assign tmo_d = state_q != ACCESS ? '0 : tmo_q + TW'(!pready);
`else
    assign abort = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        pop         = 1'b0;
        if (state_q == SETUP) begin
            state_d   = ACCESS;
            penable_d = 1'b1;
        end else if (state_q == IDLE || done) begin
            // Completion and the next issue share one edge so back-to-back transfers have no idle gap.
            pop       = !empty;
            state_d   = empty ? IDLE : SETUP;
            psel_d    = !empty;
            penable_d = 1'b0;
            if (!empty) begin
                {pwrite_d, paddr_d, pwdata_d} = head;
            end
        end
        if (done) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = (pready && !pwrite_q) ? prdata : '0;
            rsp_err_d   = pready ? pslverr : 1'b1;
        end
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    // Payload storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge pclk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {cmd_write, cmd_addr, cmd_wdata};
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
`ifdef APB_CMD_MASTER_TIMEOUT_EN
            tmo_q       <= tmo_d;
`endif
        end
    end
endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master: directed bench for apb_cmd_master with a four-register APB completer model.
`timescale 1ns/1ps
module tb_apb_cmd_master;
    logic        pclk = 1'b0;
    logic        preset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_err, busy;
    logic [31:0] rsp_rdata, paddr, pwdata, prdata;
    logic        pwrite, psel, penable, pready, pslverr;

    apb_cmd_master dut (
        .pclk(pclk), .preset(preset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy),
        .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .psel(psel), .penable(penable),
        .pready(pready), .pslverr(pslverr), .prdata(prdata)
    );

    always #5 pclk = ~pclk;

    // Completer: registers at 0x0..0xC, anything >= 0x10 errors; ws wait states per ACCESS.
    // pslverr is deliberately high during wait states to show it is ignored there.
    logic [31:0] regs [4] = '{default: '0};
    logic [31:0] last_paddr = '0;
    logic        unmapped;
    int          ws = 1;
    int          acc_cnt = 0;
    bit          hang = 1'b0;
    int          cyc = 0;

    assign unmapped = paddr >= 32'h10;
    assign pready   = psel && penable && !hang && acc_cnt >= ws;
    assign pslverr  = psel && (unmapped || !pready);
    assign prdata   = unmapped ? 32'hBAD0BAD0 : regs[paddr[3:2]];

    always @(posedge pclk) begin
        cyc     <= cyc + 1;
        acc_cnt <= (psel && penable && !pready) ? acc_cnt + 1 : 0;
        if (pready) begin
            last_paddr <= paddr;
            if (pwrite && !unmapped) regs[paddr[3:2]] <= pwdata;
        end
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } rsp_t;
    rsp_t rsp_q [$];

    always @(negedge pclk) begin
        if (rsp_valid) rsp_q.push_back('{rsp_rdata, rsp_err, cyc});
    end

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          ws;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;
    vec_t vecs [9];

    logic        b_wr    [5];
    logic [31:0] b_addr  [5];
    logic [31:0] b_wdata [5];
    logic [31:0] b_rdata [5];
    logic        b_err   [5];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic push_cmd(input logic wr, input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        while (!cmd_ready && n < 50) begin
            @(negedge pclk);
            n++;
        end
        if (!cmd_ready) check("push_cmd_ready_timeout", cmd_ready, 1);
        @(negedge pclk);
        cmd_valid = 1'b0;
    endtask

    task automatic get_rsp(output rsp_t r);
        int n = 0;
        while (rsp_q.size() == 0 && n < 100) begin
            @(negedge pclk);
            n++;
        end
        if (rsp_q.size() == 0) begin
            check("rsp_wait_timeout", 32'(rsp_q.size()), 1);
            r = '{'x, 1'bx, 0};
        end else begin
            r = rsp_q.pop_front();
        end
    endtask

    task automatic run_burst(input int n, input int spacing, input logic exp_ready_end);
        rsp_t r;
        int   prev = 0;
        for (int k = 0; k < n; k++) begin
            cmd_valid = 1'b1;
            cmd_write = b_wr[k];
            cmd_addr  = b_addr[k];
            cmd_wdata = b_wdata[k];
            check("burst_cmd_ready", cmd_ready, 1);
            @(negedge pclk);
        end
        cmd_valid = 1'b0;
        check("burst_end_cmd_ready", cmd_ready, exp_ready_end);
        for (int k = 0; k < n; k++) begin
            get_rsp(r);
            check("burst_rdata", r.rdata, b_rdata[k]);
            check("burst_err", r.err, b_err[k]);
            if (k > 0) check("burst_spacing", 32'(r.cyc - prev), 32'(spacing));
            prev = r.cyc;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rsp_t r;
        preset    = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        vecs[0] = '{1'b1, 32'h4,  32'hCAFE0001, 1, 32'h0,        1'b0};
        vecs[1] = '{1'b1, 32'hC,  32'h12345678, 0, 32'h0,        1'b0};
        vecs[2] = '{1'b0, 32'hC,  32'h0,        1, 32'h12345678, 1'b0};
        vecs[3] = '{1'b0, 32'h0,  32'h0,        2, 32'h7,        1'b0};
        vecs[4] = '{1'b0, 32'h20, 32'h0,        1, 32'hBAD0BAD0, 1'b1};
        vecs[5] = '{1'b1, 32'h24, 32'h5,        0, 32'h0,        1'b1};
        vecs[6] = '{1'b1, 32'h8,  32'hA5A5A5A5, 3, 32'h0,        1'b0};
        vecs[7] = '{1'b0, 32'h8,  32'h0,        0, 32'hA5A5A5A5, 1'b0};
        vecs[8] = '{1'b0, 32'h4,  32'h0,        0, 32'hCAFE0001, 1'b0};

        repeat (2) @(negedge pclk);
        check("rst_psel", psel, 0);
        check("rst_penable", penable, 0);
        check("rst_pwrite", pwrite, 0);
        check("rst_paddr", paddr, 0);
        check("rst_pwdata", pwdata, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_busy", busy, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        preset = 1'b0;
        @(negedge pclk);

        // First-transfer timing with a one-wait-state completer: write 0x0 = 7.
        ws        = 1;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h0;
        cmd_wdata = 32'h7;
        @(negedge pclk);
        cmd_valid = 1'b0;
        check("t1_busy", busy, 1);
        check("t1_psel", psel, 0);
        @(negedge pclk);
        check("t2_psel", psel, 1);
        check("t2_penable", penable, 0);
        check("t2_pwrite", pwrite, 1);
        check("t2_paddr", paddr, 32'h0);
        check("t2_pwdata", pwdata, 32'h7);
        @(negedge pclk);
        check("t3_psel", psel, 1);
        check("t3_penable", penable, 1);
        @(negedge pclk);
        check("t4_penable", penable, 1);
        check("t4_rsp_valid", rsp_valid, 0);
        @(negedge pclk);
        check("t5_rsp_valid", rsp_valid, 1);
        check("t5_rsp_err", rsp_err, 0);
        check("t5_rsp_rdata", rsp_rdata, 0);
        check("t5_psel", psel, 0);
        check("t5_penable", penable, 0);
        @(negedge pclk);
        check("t6_rsp_valid", rsp_valid, 0);
        check("t6_busy", busy, 0);
        rsp_q.delete();

        for (int i = 0; i < 9; i++) begin
            ws = vecs[i].ws;
            push_cmd(vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            get_rsp(r);
            check($sformatf("vec%0d_rdata", i), r.rdata, vecs[i].exp_rdata);
            check($sformatf("vec%0d_err", i), r.err, vecs[i].exp_err);
            check($sformatf("vec%0d_paddr", i), last_paddr, vecs[i].addr);
        end

        // Five commands on consecutive cycles with a slow completer: FIFO fills, order kept.
        ws = 3;
        b_wr    = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        b_addr  = '{32'h0, 32'h4, 32'h8, 32'h4, 32'h0};
        b_wdata = '{32'h11, 32'h22, 32'h33, 32'h0, 32'h0};
        b_rdata = '{32'h0, 32'h0, 32'h0, 32'h22, 32'h11};
        b_err   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        run_burst(5, 5, 1'b0);

        // Back-to-back with one wait state: 3 cycles per transfer.
        ws = 1;
        b_wr    = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        b_addr  = '{32'h8, 32'h20, 32'h0, 32'h0, 32'h0};
        b_rdata = '{32'h33, 32'hBAD0BAD0, 32'h11, 32'h0, 32'h0};
        b_err   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        run_burst(3, 3, 1'b1);

        // Reset during ACCESS with two commands queued.
        hang = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cmd_valid = 1'b1;
            cmd_write = 1'b0;
            cmd_addr  = 32'(4 * k);
            @(negedge pclk);
        end
        cmd_valid = 1'b0;
        check("pre_rst_psel", psel, 1);
        check("pre_rst_penable", penable, 1);
        #1 preset = 1'b1;
        #1;
        check("mid_rst_psel", psel, 0);
        check("mid_rst_penable", penable, 0);
        check("mid_rst_busy", busy, 0);
        @(negedge pclk);
        preset = 1'b0;
        hang   = 1'b0;
        rsp_q.delete();
        repeat (10) @(negedge pclk);
        check("post_rst_no_rsp", 32'(rsp_q.size()), 0);
        check("post_rst_busy", busy, 0);
        check("post_rst_psel", psel, 0);
        check("post_rst_cmd_ready", cmd_ready, 1);

`ifdef APB_CMD_MASTER_TIMEOUT_EN
        begin
            int acc = 0;
            int n   = 0;
            hang = 1'b1;
            push_cmd(1'b0, 32'h4, 32'h0);
            while (!rsp_valid && n < 40) begin
                @(negedge pclk);
                if (psel && penable) acc++;
                n++;
            end
            check("tmo_rsp_valid", rsp_valid, 1);
            check("tmo_access_cycles", 32'(acc), 16);
            check("tmo_rsp_err", rsp_err, 1);
            check("tmo_rsp_rdata", rsp_rdata, 0);
            check("tmo_psel", psel, 0);
            hang = 1'b0;
            @(negedge pclk);
            rsp_q.delete();
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
